// File: rtl/count_constraint_if.sv
// Bus between the NFA engine and a counted-repetition unit.
// Carries the per-cycle control (en/inc/clr), the runtime bound
// programming port (cfg_*) and the unit's results (out/count/over).
//   master : engine side, drives control and configuration
//   slave  : count_constraint_unit side, drives results
interface count_constraint_if #(
   parameter int K = 4
);
   logic         en;
   logic         inc;
   logic         clr;
   logic         cfg_we;
   logic [K-1:0] cfg_min;
   logic [K-1:0] cfg_max;
   logic [1:0]   cfg_mode;
   logic         out;
   logic [K-1:0] count;
   logic         over;

   modport master (
      output en, inc, clr, cfg_we, cfg_min, cfg_max, cfg_mode,
      input  out, count, over
   );

   modport slave (
      input  en, inc, clr, cfg_we, cfg_min, cfg_max, cfg_mode,
      output out, count, over
   );
endinterface

// File: rtl/count_constraint_unit.sv
// Counted-repetition unit for the NFA engine. Counts consecutive matches of
// a constrained sub-pattern and flags when the count satisfies a runtime
// programmable {min,max} bound.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (bounds revert to parameter defaults)
//   bus  : count_constraint_if slave
//          en       global enable, gates clr and inc
//          inc      one matched repetition this cycle
//          clr      run broken, restart count (clr+inc restarts at 1)
//          cfg_we   load cfg_min/cfg_max/cfg_mode, clears count and over
//          out      bound satisfied (registered state only)
//          count    current repetition count, saturating
//          over     sticky, run exceeded max (modes 0/1)
// Modes: 0 = at-most, 1 (and 3) = between/exactly, 2 = at-least.
module count_constraint_unit #(
   parameter int K        = 4,
   parameter int MIN_DEF  = 3,
   parameter int MAX_DEF  = 3,
   parameter int MODE_DEF = 1
) (
   input logic              clk,
   input logic              rst,
   count_constraint_if.slave bus
);

   localparam logic [K-1:0] CNT_ONE  = K'(1);
   localparam logic [K-1:0] CNT_TOP  = '1;
   localparam logic [K-1:0] MIN_INIT = K'(MIN_DEF);
   localparam logic [K-1:0] MAX_INIT = K'(MAX_DEF);
   localparam logic [1:0]   MODE_INIT = 2'(MODE_DEF);

   typedef struct packed {
      logic [1:0]   mode;
      logic [K-1:0] max;
      logic [K-1:0] min;
   } bound_t;

   bound_t       bnd;
   logic [K-1:0] cnt;
   logic         ovr;
   logic         armed;     // low only in the cycle right after reset
   logic [K-1:0] cnt_nxt;
   logic         ovr_nxt;
   logic         at_least;

   assign at_least = (bnd.mode == 2'd2);

   // Run update for the non-reset, non-configuration case.
   always_comb begin
      cnt_nxt = cnt;
      ovr_nxt = ovr;
      if (bus.en) begin
         if (bus.clr) begin
            cnt_nxt = bus.inc ? CNT_ONE : '0;
            ovr_nxt = 1'b0;
         end else if (bus.inc) begin
            if (at_least) begin
               // Saturate at min: further repetitions cannot change out.
               if ((cnt < bnd.min) && (cnt != CNT_TOP))
                  cnt_nxt = cnt + CNT_ONE;
            end else begin
               // At or beyond max the count holds and the run is marked bad.
               if ((cnt < bnd.max) && (cnt != CNT_TOP))
                  cnt_nxt = cnt + CNT_ONE;
               else
                  ovr_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         ovr      <= 1'b0;
         armed    <= 1'b0;
         bnd.min  <= MIN_INIT;
         bnd.max  <= MAX_INIT;
         bnd.mode <= MODE_INIT;
      end else begin
         armed <= 1'b1;
         if (bus.cfg_we) begin
            cnt      <= '0;
            ovr      <= 1'b0;
            bnd.min  <= bus.cfg_min;
            bnd.max  <= bus.cfg_max;
            bnd.mode <= bus.cfg_mode;
         end else begin
            cnt <= cnt_nxt;
            ovr <= ovr_nxt;
         end
      end
   end

   // Result depends on registers only, so it trails the completing inc by one cycle.
   always_comb begin
      bus.out = 1'b0;
      if (armed) begin
         case (bnd.mode)
            2'd0:    bus.out = (cnt >= CNT_ONE) && (cnt <= bnd.max) && !ovr;
            2'd2:    bus.out = (cnt >= bnd.min);
            default: bus.out = (cnt >= bnd.min) && (cnt <= bnd.max) && !ovr;
         endcase
      end
   end

   assign bus.count = cnt;
   assign bus.over  = ovr;

endmodule

// File: tb/tb_count_constraint_unit.sv
module tb_count_constraint_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   count_constraint_if #(.K(4)) m_if ();
   count_constraint_if #(.K(2)) c_if ();

   // Ceiling instance shares the control stream, never reconfigured.
   assign c_if.en       = m_if.en;
   assign c_if.inc      = m_if.inc;
   assign c_if.clr      = m_if.clr;
   assign c_if.cfg_we   = 1'b0;
   assign c_if.cfg_min  = 2'd0;
   assign c_if.cfg_max  = 2'd0;
   assign c_if.cfg_mode = 2'd0;

   count_constraint_unit #(.K(4), .MIN_DEF(3), .MAX_DEF(3), .MODE_DEF(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (m_if.slave)
   );

   count_constraint_unit #(.K(2), .MIN_DEF(3), .MAX_DEF(3), .MODE_DEF(2)) dut_c (
      .clk (clk),
      .rst (rst),
      .bus (c_if.slave)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int cnt;
      int ovr;
      int out;
      bit ceil;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue the expected post-edge state, then
   // pop and compare it against the DUT after the edge.
   task automatic step(input bit r, input bit e, input bit i, input bit c,
                       input bit we, input int mn, input int mx, input int md,
                       input int ec, input int eo, input int eout);
      exp_t x;
      @(negedge clk);
      rst           = r;
      m_if.en       = e;
      m_if.inc      = i;
      m_if.clr      = c;
      m_if.cfg_we   = we;
      m_if.cfg_min  = 4'(mn);
      m_if.cfg_max  = 4'(mx);
      m_if.cfg_mode = 2'(md);
      x.cnt = ec; x.ovr = eo; x.out = eout; x.ceil = 1'b0;
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("count", int'(m_if.count), x.cnt);
      chk("over",  int'(m_if.over),  x.ovr);
      chk("out",   int'(m_if.out),   x.out);
   endtask

   task automatic step_c(input bit r, input bit i, input int ec, input int eout);
      exp_t x;
      @(negedge clk);
      rst         = r;
      m_if.en     = 1'b1;
      m_if.inc    = i;
      m_if.clr    = 1'b0;
      m_if.cfg_we = 1'b0;
      x.cnt = ec; x.ovr = 0; x.out = eout; x.ceil = 1'b1;
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("ceil_count", int'(c_if.count), x.cnt);
      chk("ceil_over",  int'(c_if.over),  x.ovr);
      chk("ceil_out",   int'(c_if.out),   x.out);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      m_if.en = 1'b0; m_if.inc = 1'b0; m_if.clr = 1'b0; m_if.cfg_we = 1'b0;
      m_if.cfg_min = '0; m_if.cfg_max = '0; m_if.cfg_mode = '0;

      //   r e i c we mn mx md   cnt ovr out
      // Reset and defaults 3/3 mode 1
      step(1,1,0,0,0, 0,0,0,   0,0,0);
      step(0,1,1,0,0, 0,0,0,   1,0,0);
      step(0,1,1,0,0, 0,0,0,   2,0,0);
      step(0,1,1,0,0, 0,0,0,   3,0,1);
      step(0,1,1,0,0, 0,0,0,   3,1,0);
      step(0,1,1,0,0, 0,0,0,   3,1,0);
      // Restart
      step(0,1,0,1,0, 0,0,0,   0,0,0);
      step(0,1,1,0,0, 0,0,0,   1,0,0);
      step(0,1,1,0,0, 0,0,0,   2,0,0);
      step(0,1,1,1,0, 0,0,0,   1,0,0);
      step(0,1,0,1,0, 0,0,0,   0,0,0);
      // Mode 2, min 5
      step(0,1,0,0,1, 5,9,2,   0,0,0);
      step(0,1,1,0,0, 0,0,0,   1,0,0);
      step(0,1,1,0,0, 0,0,0,   2,0,0);
      step(0,1,1,0,0, 0,0,0,   3,0,0);
      step(0,1,1,0,0, 0,0,0,   4,0,0);
      step(0,1,1,0,0, 0,0,0,   5,0,1);
      step(0,1,1,0,0, 0,0,0,   5,0,1);
      step(0,1,1,0,0, 0,0,0,   5,0,1);
      // Mode 2, min 0: satisfied with no repetitions
      step(0,1,0,0,1, 0,9,2,   0,0,1);
      // Mode 0, max 2
      step(0,1,0,0,1, 0,2,0,   0,0,0);
      step(0,1,1,0,0, 0,0,0,   1,0,1);
      step(0,1,1,0,0, 0,0,0,   2,0,1);
      step(0,1,1,0,0, 0,0,0,   2,1,0);
      step(0,1,1,0,0, 0,0,0,   2,1,0);
      step(0,1,0,1,0, 0,0,0,   0,0,0);
      // Mode 0, max 0: first inc overflows
      step(0,1,0,0,1, 0,0,0,   0,0,0);
      step(0,1,1,0,0, 0,0,0,   0,1,0);
      // Mode 1, min > max: never satisfied
      step(0,1,0,0,1, 3,1,1,   0,0,0);
      step(0,1,1,0,0, 0,0,0,   1,0,0);
      step(0,1,1,0,0, 0,0,0,   1,1,0);
      // Mode 3 behaves as mode 1, 2..3
      step(0,1,0,0,1, 2,3,3,   0,0,0);
      step(0,1,1,0,0, 0,0,0,   1,0,0);
      step(0,1,1,0,0, 0,0,0,   2,0,1);
      step(0,1,1,0,0, 0,0,0,   3,0,1);
      step(0,1,1,0,0, 0,0,0,   3,1,0);
      // Enable gating and priority
      step(0,1,0,0,1, 3,3,1,   0,0,0);
      step(0,1,1,0,0, 0,0,0,   1,0,0);
      step(0,1,1,0,0, 0,0,0,   2,0,0);
      for (int n = 0; n < 4; n++)
         step(0,0,1,0,0, 0,0,0, 2,0,0);
      step(0,0,1,1,0, 0,0,0,   2,0,0);
      step(0,1,1,1,1, 1,2,1,   0,0,0);
      step(0,1,1,0,0, 0,0,0,   1,0,1);
      step(0,1,1,0,0, 0,0,0,   2,0,1);
      // Reset mid-run reverts to defaults 3/3 mode 1
      step(1,1,1,0,0, 0,0,0,   0,0,0);
      step(0,1,1,0,0, 0,0,0,   1,0,0);
      step(0,1,1,0,0, 0,0,0,   2,0,0);
      step(0,1,1,0,0, 0,0,0,   3,0,1);

      // Ceiling: K=2, mode 2, min 3
      step_c(1,0, 0,0);
      step_c(0,1, 1,0);
      step_c(0,1, 2,0);
      step_c(0,1, 3,1);
      step_c(0,1, 3,1);
      step_c(0,1, 3,1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
